iter_shifter: RTL and testbench
===============================

# iter_shifter

Multi-cycle shift unit in the EX stage. It consumes the 5-bit shift amount `ShiftsE` chosen by the shift-source mux, together with the operand and shift opcode. It computes SLL/SRL/SRA iteratively, moving up to `STEP` bit positions per cycle. While a shift is in flight it raises a busy flag that the hazard unit uses to stall the pipeline, and it pulses done when the result is valid.

## Interface
- `STEP`, 4, max bit positions shifted per cycle; legal values are 1, 2, 4, 8 or 16.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `StartE`  in  1  request to start a shift; sampled only in IDLE or DONE.
- `ShiftOpE`  in  2  operation: `SHIFT_SLL`=2'b00, `SHIFT_SRL`=2'b01, `SHIFT_SRA`=2'b11; 2'b10 is reserved and executes as SLL.
- `ShiftsE`  in  `R_SIZE` (5)  shift amount, 0..31.
- `SrcBE`  in  `DATALENGTH` (32)  operand to shift (rt).
- `FlushE`  in  1  abort the current operation.
- `ShiftResultE`  out  32  result; held stable from done until the next accepted start.
- `ShiftBusyE`  out  1  high while in RUN; used as the stall request.
- `ShiftDoneE`  out  1  one-cycle pulse when `ShiftResultE` is valid.

## Operation
- States: IDLE, RUN, DONE. Encodings are kept in the shared defines.
- Registers:
  - `acc[31:0]`: working value.
  - `rem[4:0]`: remaining bit positions.
  - `op[1:0]`: latched opcode.
- IDLE or DONE with `StartE`=1 and `FlushE`=0:
  - load `acc`=`SrcBE`, `rem`=`ShiftsE`, `op`=`ShiftOpE`.
  - next state is RUN if `ShiftsE`≠0, otherwise DONE.
- IDLE with `StartE`=0: stay in IDLE.
- DONE with `StartE`=0: go to IDLE.
- RUN, each cycle:
  - k = min(`rem`, `STEP`).
  - `acc` is shifted by k: SLL fills with zeros; SRL fills with zeros; SRA fills with `acc[31]`.
  - `rem` -= k.
  - When `rem` reaches 0 after the update, next state is DONE.
- `StartE` during RUN is ignored. The issuing stage is stalled, so no request is lost.
- `FlushE`=1 in any state: next state is IDLE.
  - `ShiftDoneE` is not asserted for the aborted operation.
  - `ShiftResultE` keeps its previous value.
- `FlushE` and `StartE` asserted together: flush wins and the start is dropped.
- `ShiftResultE` is a registered copy of `acc`, updated on entry to DONE.
- The output never exposes intermediate values.

## Timing
- Reset (`reset`=0, asynchronous):
  - state = IDLE.
  - `acc`, `rem`, `op` and `ShiftResultE` = 0.
  - `ShiftBusyE`=0, `ShiftDoneE`=0.
- Start accepted at the edge ending cycle 0:
  - `ShiftsE`=0: `ShiftDoneE`=1 in cycle 1; `ShiftBusyE` never rises.
  - `ShiftsE`=n>0: `ShiftBusyE`=1 for cycles 1..ceil(n/STEP), and `ShiftDoneE`=1 in cycle ceil(n/STEP)+1.
- Worst case with `STEP`=4: n=31 gives busy for 8 cycles and done in cycle 9.
- Back-to-back: a start accepted in the DONE cycle launches the next operation with no idle bubble.
- Reset asserted mid-RUN clears state immediately; no done pulse follows.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- `defines.vh` holds `SHIFT_SLL`/`SHIFT_SRL`/`SHIFT_SRA`, the state encodings `SHS_IDLE`/`SHS_RUN`/`SHS_DONE`, plus the existing `DATALENGTH` and `R_SIZE`.
- Sub-module `shift_step`: combinational one-step shifter.
  - Inputs: `acc`, k (0..`STEP`), `op`.
  - Output: shifted value.
  - Instantiated once; the FSM and registers live in `iter_shifter`.

## Test plan
- SLL, `SrcBE`=0x00000001, `ShiftsE`=31, `STEP`=4 -> busy in cycles 1-8, done in cycle 9, result 0x80000000.
- SRA, `SrcBE`=0x80000000, `ShiftsE`=4 -> done in cycle 2, result 0xF8000000. SRL with the same inputs -> 0x08000000.
- `ShiftsE`=0, SRA, `SrcBE`=0xDEADBEEF -> busy stays 0, done in cycle 1, result 0xDEADBEEF.
- SRL 0xFFFFFFFF by 13 with `FlushE` pulsed in cycle 2 -> IDLE in cycle 3, no done pulse, result unchanged. A new start afterwards completes normally.
- Back-to-back:
  - SLL 0x3 by 5 finishes with done in cycle 3 and result 0x60.
  - Start asserted in that DONE cycle: SRA 0x80000000 by 1 gives done in cycle 5 and result 0xC0000000.
- `reset` low during RUN -> all outputs 0 immediately, state IDLE.
- Repeat the SLL-by-31 case with `STEP`=1 -> done in cycle 32.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// iter_shifter_pkg: shared constants and types for the iterative shift unit.
//   DATALENGTH / R_SIZE : datapath and shift-amount widths
//   SHIFT_*             : shift opcodes (2'b10 is reserved and behaves as SLL)
//   shState_t           : FSM state encodings
//   minStep()           : per-cycle shift distance, min(rem, step)
package iter_shifter_pkg;

  localparam int DATALENGTH = 32;
  localparam int R_SIZE     = 5;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b11;

  typedef enum logic [1:0] {
    SHS_IDLE = 2'b00,
    SHS_RUN  = 2'b01,
    SHS_DONE = 2'b10
  } shState_t;

  // step is at most 16, so it always fits in R_SIZE bits.
  function automatic logic [R_SIZE-1:0] minStep(input logic [R_SIZE-1:0] rem,
                                                input int step);
    logic [R_SIZE-1:0] s;
    s = R_SIZE'(step);
    return (rem > s) ? s : rem;
  endfunction

endpackage

// File: rtl/iter_shifter_shift_step.sv
// shift_step: combinational single-step shifter.
//   acc     : value to shift
//   k       : shift distance for this step (0..STEP of the parent)
//   op      : SHIFT_SLL / SHIFT_SRL / SHIFT_SRA (reserved code -> SLL)
//   shifted : acc shifted by k
module shift_step
  import iter_shifter_pkg::*;
(
  input  logic [DATALENGTH-1:0] acc,
  input  logic [R_SIZE-1:0]     k,
  input  logic [1:0]            op,
  output logic [DATALENGTH-1:0] shifted
);

  always_comb begin
    shifted = acc << k;
    case (op)
      SHIFT_SRL: shifted = acc >> k;
      SHIFT_SRA: shifted = DATALENGTH'($signed(acc) >>> k);
      default:   shifted = acc << k;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle SLL/SRL/SRA unit for the EX stage.
// Moves up to STEP bit positions per cycle (STEP in {1,2,4,8,16}).
//   clock, reset  : rising-edge clock, async active-low reset
//   StartE        : start request, honoured only in IDLE/DONE
//   ShiftOpE      : opcode, ShiftsE : amount 0..31, SrcBE : operand
//   FlushE        : abort; wins over StartE, suppresses the done pulse
//   ShiftResultE  : result, held from done until the next completion
//   ShiftBusyE    : high in RUN (stall request)
//   ShiftDoneE    : one-cycle pulse when ShiftResultE is valid
// All outputs are registered and computed from the next-state decision,
// so they line up with the state they describe.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  StartE,
  input  logic [1:0]            ShiftOpE,
  input  logic [R_SIZE-1:0]     ShiftsE,
  input  logic [DATALENGTH-1:0] SrcBE,
  input  logic                  FlushE,
  output logic [DATALENGTH-1:0] ShiftResultE,
  output logic                  ShiftBusyE,
  output logic                  ShiftDoneE
);

  shState_t              state;
  logic [DATALENGTH-1:0] acc;
  logic [R_SIZE-1:0]     rem;
  logic [1:0]            op;

  logic [R_SIZE-1:0]     k;
  logic [R_SIZE-1:0]     remNext;
  logic [DATALENGTH-1:0] accNext;

  assign k       = minStep(rem, STEP);
  assign remNext = rem - k;

  shift_step uStep (
    .acc     (acc),
    .k       (k),
    .op      (op),
    .shifted (accNext)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= SHS_IDLE;
      acc          <= '0;
      rem          <= '0;
      op           <= SHIFT_SLL;
      ShiftResultE <= '0;
      ShiftBusyE   <= 1'b0;
      ShiftDoneE   <= 1'b0;
    end else begin
      ShiftBusyE <= 1'b0;
      ShiftDoneE <= 1'b0;
      if (FlushE) begin
        // Abort: result register keeps the last completed value.
        state <= SHS_IDLE;
      end else begin
        case (state)
          SHS_IDLE, SHS_DONE: begin
            if (StartE) begin
              acc <= SrcBE;
              rem <= ShiftsE;
              op  <= ShiftOpE;
              if (ShiftsE != '0) begin
                state      <= SHS_RUN;
                ShiftBusyE <= 1'b1;
              end else begin
                // Zero-length shift completes without ever going busy.
                state        <= SHS_DONE;
                ShiftDoneE   <= 1'b1;
                ShiftResultE <= SrcBE;
              end
            end else begin
              state <= SHS_IDLE;
            end
          end
          SHS_RUN: begin
            acc <= accNext;
            rem <= remNext;
            if (remNext == '0) begin
              state        <= SHS_DONE;
              ShiftDoneE   <= 1'b1;
              ShiftResultE <= accNext;
            end else begin
              ShiftBusyE <= 1'b1;
            end
          end
          default: state <= SHS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed bench for iter_shifter (STEP=4 and STEP=1 instances).
module tb_iter_shifter;
  import iter_shifter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        StartE = 1'b0;
  logic        FlushE = 1'b0;
  logic [1:0]  ShiftOpE = 2'b00;
  logic [4:0]  ShiftsE = 5'd0;
  logic [31:0] SrcBE = 32'd0;

  logic [31:0] res4, res1;
  logic        busy4, done4, busy1, done1;

  always #5 clock = ~clock;

  iter_shifter #(.STEP(4)) dut4 (
    .clock(clock), .reset(reset), .StartE(StartE), .ShiftOpE(ShiftOpE),
    .ShiftsE(ShiftsE), .SrcBE(SrcBE), .FlushE(FlushE),
    .ShiftResultE(res4), .ShiftBusyE(busy4), .ShiftDoneE(done4)
  );

  iter_shifter #(.STEP(1)) dut1 (
    .clock(clock), .reset(reset), .StartE(StartE), .ShiftOpE(ShiftOpE),
    .ShiftsE(ShiftsE), .SrcBE(SrcBE), .FlushE(FlushE),
    .ShiftResultE(res1), .ShiftBusyE(busy1), .ShiftDoneE(done1)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] s, input int n);
    case (o)
      2'b01:   return s >> n;
      2'b11:   return $signed(s) >>> n;
      default: return s << n;
    endcase
  endfunction

  // Drives one start (call at a negedge); returns at the negedge of the
  // done cycle so a caller can chain a back-to-back start.
  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] s,
                       input int n, input int stepv, input bit slow);
    exp_t e, got;
    int   lat, cyc;
    bit   seen;
    logic b, d;
    logic [31:0] r;
    lat = (n == 0) ? 1 : (n + stepv - 1) / stepv + 1;
    e.res = model(o, s, n);
    e.cyc = lat;
    sbq.push_back(e);
    StartE = 1'b1; ShiftOpE = o; SrcBE = s; ShiftsE = n[4:0];
    @(negedge clock);
    StartE = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (1) begin
      b = slow ? busy1 : busy4;
      d = slow ? done1 : done4;
      r = slow ? res1  : res4;
      check({tag, " busy"}, 64'(b), 64'(cyc < lat));
      if (d) begin
        got = sbq.pop_front();
        check({tag, " result"}, 64'(r), 64'(got.res));
        check({tag, " done cycle"}, 64'(cyc), 64'(got.cyc));
        seen = 1'b1;
        break;
      end
      if (cyc >= lat + 3) break;
      @(negedge clock);
      cyc++;
    end
    if (!seen) begin
      check({tag, " done timeout"}, 64'(0), 64'(1));
      void'(sbq.pop_front());
    end
  endtask

  initial begin
    logic [31:0] prev;
    logic [1:0]  ops [4];
    ops[0] = 2'b00; ops[1] = 2'b01; ops[2] = 2'b11; ops[3] = 2'b10;

    // Reset state
    #12;
    check("reset res4", 64'(res4), 64'(0));
    check("reset busy4", 64'(busy4), 64'(0));
    check("reset done4", 64'(done4), 64'(0));
    check("reset res1", 64'(res1), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Worst case at STEP=4
    runOp("sll31", SHIFT_SLL, 32'h00000001, 31, 4, 1'b0);
    check("sll31 const", 64'(res4), 64'(32'h80000000));
    @(negedge clock);
    runOp("sra4", SHIFT_SRA, 32'h80000000, 4, 4, 1'b0);
    check("sra4 const", 64'(res4), 64'(32'hF8000000));
    @(negedge clock);
    runOp("srl4", SHIFT_SRL, 32'h80000000, 4, 4, 1'b0);
    check("srl4 const", 64'(res4), 64'(32'h08000000));
    @(negedge clock);
    runOp("sra0", SHIFT_SRA, 32'hDEADBEEF, 0, 4, 1'b0);
    check("sra0 const", 64'(res4), 64'(32'hDEADBEEF));
    @(negedge clock);
    check("done pulse width", 64'(done4), 64'(0));

    // Random mix, including the reserved opcode
    for (int i = 0; i < 6; i++) begin
      runOp("rand", ops[$urandom_range(0, 3)], $urandom(), $urandom_range(0, 31), 4, 1'b0);
      @(negedge clock);
    end

    // Flush mid-RUN
    prev = res4;
    StartE = 1'b1; ShiftOpE = SHIFT_SRL; SrcBE = 32'hFFFFFFFF; ShiftsE = 5'd13;
    @(negedge clock);                // cycle 1
    StartE = 1'b0;
    check("flush busy c1", 64'(busy4), 64'(1));
    @(negedge clock);                // cycle 2
    FlushE = 1'b1;
    @(negedge clock);                // cycle 3
    FlushE = 1'b0;
    check("flush busy c3", 64'(busy4), 64'(0));
    check("flush result held", 64'(res4), 64'(prev));
    for (int i = 0; i < 5; i++) begin
      check("flush no done", 64'(done4), 64'(0));
      @(negedge clock);
    end
    runOp("after flush", SHIFT_SRL, 32'hFFFFFFFF, 13, 4, 1'b0);
    check("after flush const", 64'(res4), 64'(32'h0007FFFF));
    @(negedge clock);

    // Flush together with start: start dropped
    prev = res4;
    StartE = 1'b1; FlushE = 1'b1; ShiftOpE = SHIFT_SLL; SrcBE = 32'h1; ShiftsE = 5'd0;
    @(negedge clock);
    StartE = 1'b0; FlushE = 1'b0;
    check("flush+start done", 64'(done4), 64'(0));
    check("flush+start result", 64'(res4), 64'(prev));
    @(negedge clock);

    // Back-to-back: second start issued in the DONE cycle
    runOp("b2b sll", SHIFT_SLL, 32'h3, 5, 4, 1'b0);
    check("b2b sll const", 64'(res4), 64'(32'h60));
    runOp("b2b sra", SHIFT_SRA, 32'h80000000, 1, 4, 1'b0);
    check("b2b sra const", 64'(res4), 64'(32'hC0000000));
    @(negedge clock);

    // Async reset during RUN
    StartE = 1'b1; ShiftOpE = SHIFT_SLL; SrcBE = 32'h1; ShiftsE = 5'd31;
    @(negedge clock);
    StartE = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst run res", 64'(res4), 64'(0));
    check("rst run busy", 64'(busy4), 64'(0));
    check("rst run done", 64'(done4), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("rst no done", 64'(done4), 64'(0));
    end

    // STEP=1 worst case
    runOp("step1 sll31", SHIFT_SLL, 32'h00000001, 31, 1, 1'b1);
    check("step1 const", 64'(res1), 64'(32'h80000000));
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
